// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;
    localparam int SEL_RF = 0;
    localparam int CNT_W  = 16;

    // Stall counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and EX-forwarding/stall response bundle of the hazard unit.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int NUM_STAGES = 2
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic              id_valid_i;
    logic [ADDR_W-1:0] id_rs_addr_i;
    logic [ADDR_W-1:0] id_rt_addr_i;
    logic              id_uses_rs_i;
    logic              id_uses_rt_i;
    logic              id_write_i;
    logic [ADDR_W-1:0] id_write_addr_i;
    logic              id_memread_i;
    logic              flush_i;
    logic              stall_o;
    logic [SEL_W-1:0]  rs_muxcontrol_o;
    logic [SEL_W-1:0]  rt_muxcontrol_o;
    logic [CNT_W-1:0]  stall_count_o;

    modport master (
        output id_valid_i, id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
               id_write_i, id_write_addr_i, id_memread_i, flush_i,
        input  stall_o, rs_muxcontrol_o, rt_muxcontrol_o, stall_count_o
    );

    modport slave (
        input  id_valid_i, id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
               id_write_i, id_write_addr_i, id_memread_i, flush_i,
        output stall_o, rs_muxcontrol_o, rt_muxcontrol_o, stall_count_o
    );
endinterface

// File: rtl/fwd_track_pipe.sv
// Shift table of in-flight destinations; index 0 is the instruction one stage past ID.
module fwd_track_pipe #(
    parameter int NUM_STAGES = 2,
    parameter int ENT_W      = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_ins_en,
    input  logic [ENT_W-1:0]                     i_ins_entry,
    output logic [NUM_STAGES-1:0][ENT_W-1:0]     o_entries
);
    logic [NUM_STAGES-1:0][ENT_W-1:0] r_tab;

    // Everything shifts every cycle; a held or killed ID instruction becomes an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tab <= '0;
        end else begin
            r_tab[0] <= i_ins_en ? i_ins_entry : '0;
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_tab[k] <= r_tab[k-1];
            end
        end
    end

    assign o_entries = r_tab;
endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects and load-use stall generation for the ID instruction.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int NUM_STAGES  = 2,
    parameter int LOAD_LAT    = 1,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);
    localparam int ENT_W = ADDR_W + 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              memread;
    } fwd_entry_t;

    fwd_entry_t [NUM_STAGES-1:0] w_ent;
    fwd_entry_t                  w_ins;
    logic                        w_ins_en;
    logic [SEL_W-1:0]            w_rs_sel, w_rt_sel;
    logic                        w_rs_ld, w_rt_ld;
    logic                        w_stall, w_issue;
    logic [SEL_W-1:0]            r_rs_sel, r_rt_sel;
    logic [CNT_W-1:0]            r_cnt;

    function automatic logic src_hit(input fwd_entry_t e, input logic [ADDR_W-1:0] a,
                                     input logic used);
        return used && e.valid && (e.addr == a) && !(ZERO_REG_EN && (a == '0));
    endfunction

    // Walk oldest to youngest so the smallest matching distance is the one left standing.
    always_comb begin
        w_rs_sel = SEL_W'(SEL_RF);
        w_rt_sel = SEL_W'(SEL_RF);
        w_rs_ld  = 1'b0;
        w_rt_ld  = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (src_hit(w_ent[k-1], bus.id_rs_addr_i, bus.id_uses_rs_i)) begin
                w_rs_sel = SEL_W'(k);
                w_rs_ld  = w_ent[k-1].memread && (k <= LOAD_LAT);
            end
            if (src_hit(w_ent[k-1], bus.id_rt_addr_i, bus.id_uses_rt_i)) begin
                w_rt_sel = SEL_W'(k);
                w_rt_ld  = w_ent[k-1].memread && (k <= LOAD_LAT);
            end
        end
    end

    assign w_stall  = bus.id_valid_i && !bus.flush_i && (w_rs_ld || w_rt_ld);
    assign w_issue  = bus.id_valid_i && !w_stall && !bus.flush_i;
    assign w_ins_en = w_issue && bus.id_write_i;
    assign w_ins    = '{valid: 1'b1, addr: bus.id_write_addr_i, memread: bus.id_memread_i};

    fwd_track_pipe #(
        .NUM_STAGES (NUM_STAGES),
        .ENT_W      (ENT_W)
    ) u_track (
        .clk         (clk),
        .rst         (rst),
        .i_ins_en    (w_ins_en),
        .i_ins_entry (w_ins),
        .o_entries   (w_ent)
    );

    // A bubble entering EX must read the register file, hence the forced zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs_sel <= '0;
            r_rt_sel <= '0;
            r_cnt    <= '0;
        end else begin
            r_rs_sel <= w_issue ? w_rs_sel : '0;
            r_rt_sel <= w_issue ? w_rt_sel : '0;
            if (w_stall) r_cnt <= sat_inc(r_cnt);
        end
    end

    assign bus.stall_o         = w_stall;
    assign bus.rs_muxcontrol_o = r_rs_sel;
    assign bus.rt_muxcontrol_o = r_rt_sel;
    assign bus.stall_count_o   = r_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed checks of three hazard-unit configurations driven by one shared stimulus.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v, urs, urt, wr, mr, fl;
    logic [2:0] rs, rt, wa;
    int n_tests = 0;
    int n_fail  = 0;

    fwd_hazard_unit_if #(.ADDR_W(3), .NUM_STAGES(2)) ifa ();
    fwd_hazard_unit_if #(.ADDR_W(3), .NUM_STAGES(4)) ifb ();
    fwd_hazard_unit_if #(.ADDR_W(3), .NUM_STAGES(2)) ifc ();

    assign ifa.id_valid_i = v;   assign ifb.id_valid_i = v;   assign ifc.id_valid_i = v;
    assign ifa.id_rs_addr_i = rs; assign ifb.id_rs_addr_i = rs; assign ifc.id_rs_addr_i = rs;
    assign ifa.id_rt_addr_i = rt; assign ifb.id_rt_addr_i = rt; assign ifc.id_rt_addr_i = rt;
    assign ifa.id_uses_rs_i = urs; assign ifb.id_uses_rs_i = urs; assign ifc.id_uses_rs_i = urs;
    assign ifa.id_uses_rt_i = urt; assign ifb.id_uses_rt_i = urt; assign ifc.id_uses_rt_i = urt;
    assign ifa.id_write_i = wr;  assign ifb.id_write_i = wr;  assign ifc.id_write_i = wr;
    assign ifa.id_write_addr_i = wa; assign ifb.id_write_addr_i = wa; assign ifc.id_write_addr_i = wa;
    assign ifa.id_memread_i = mr; assign ifb.id_memread_i = mr; assign ifc.id_memread_i = mr;
    assign ifa.flush_i = fl;     assign ifb.flush_i = fl;     assign ifc.flush_i = fl;

    fwd_hazard_unit #(.ADDR_W(3), .NUM_STAGES(2), .LOAD_LAT(1), .ZERO_REG_EN(1'b0))
        ua (.clk(clk), .rst(rst), .bus(ifa));
    fwd_hazard_unit #(.ADDR_W(3), .NUM_STAGES(4), .LOAD_LAT(2), .ZERO_REG_EN(1'b0))
        ub (.clk(clk), .rst(rst), .bus(ifb));
    fwd_hazard_unit #(.ADDR_W(3), .NUM_STAGES(2), .LOAD_LAT(1), .ZERO_REG_EN(1'b1))
        uc (.clk(clk), .rst(rst), .bus(ifc));

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic iv, input logic [2:0] irs, input logic iurs,
                         input logic [2:0] irt, input logic iurt, input logic iwr,
                         input logic [2:0] iwa, input logic imr, input logic ifl);
        v = iv; rs = irs; urs = iurs; rt = irt; urt = iurt;
        wr = iwr; wa = iwa; mr = imr; fl = ifl;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_stall", int'(ifa.stall_o), 0);
        chk("rst_rs_sel", int'(ifa.rs_muxcontrol_o), 0);
        chk("rst_rt_sel", int'(ifa.rt_muxcontrol_o), 0);
        chk("rst_count", int'(ifa.stall_count_o), 0);

        // add r3 ; add r1, r3
        issue(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        chk("alu_stall0", int'(ifa.stall_o), 0);
        tick();
        issue(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        chk("alu_stall1", int'(ifa.stall_o), 0);
        tick();
        idle();
        chk("alu_rs_sel", int'(ifa.rs_muxcontrol_o), 1);
        chk("alu_rt_sel", int'(ifa.rt_muxcontrol_o), 0);

        // lw r2 ; add r4, r2
        do_reset();
        issue(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        tick();
        issue(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        chk("ld_stall_c1", int'(ifa.stall_o), 1);
        tick();
        chk("ld_stall_c2", int'(ifa.stall_o), 0);
        chk("ld_bubble_sel", int'(ifa.rs_muxcontrol_o), 0);
        tick();
        idle();
        chk("ld_rs_sel", int'(ifa.rs_muxcontrol_o), 2);
        chk("ld_count", int'(ifa.stall_count_o), 1);

        // add r5 ; add r5 ; reader of r5 on both sources
        do_reset();
        issue(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        tick();
        issue(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("young_stall", int'(ifa.stall_o), 0);
        tick();
        idle();
        chk("young_rs_sel", int'(ifa.rs_muxcontrol_o), 1);
        chk("young_rt_sel", int'(ifa.rt_muxcontrol_o), 1);

        // NUM_STAGES=4, LOAD_LAT=2: lw r6 ; reader of r6 on rt
        do_reset();
        issue(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
        tick();
        issue(1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        chk("deep_stall_c1", int'(ifb.stall_o), 1);
        tick();
        chk("deep_stall_c2", int'(ifb.stall_o), 1);
        tick();
        chk("deep_stall_c3", int'(ifb.stall_o), 0);
        tick();
        idle();
        chk("deep_rt_sel", int'(ifb.rt_muxcontrol_o), 3);
        chk("deep_count", int'(ifb.stall_count_o), 2);

        // Flush over a load-use hazard; the flushed writer of r7 must not enter the table
        do_reset();
        issue(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        tick();
        issue(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
        chk("flush_stall", int'(ifa.stall_o), 0);
        tick();
        chk("flush_rs_sel", int'(ifa.rs_muxcontrol_o), 0);
        issue(1'b1, 3'd7, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("flush_after_stall", int'(ifa.stall_o), 0);
        tick();
        idle();
        chk("flush_bubble_rs", int'(ifa.rs_muxcontrol_o), 0);
        chk("flush_load_rt", int'(ifa.rt_muxcontrol_o), 2);
        chk("flush_count", int'(ifa.stall_count_o), 0);

        // ZERO_REG_EN: writer r0 ; reader r0
        do_reset();
        issue(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
        tick();
        issue(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("zero_stall", int'(ifc.stall_o), 0);
        chk("zero_stall_nozero", int'(ifa.stall_o), 1);
        tick();
        idle();
        chk("zero_rs_sel", int'(ifc.rs_muxcontrol_o), 0);

        // Reset in the middle of a stall
        do_reset();
        issue(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        issue(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        chk("rstmid_stall_pre", int'(ifc.stall_o), 1);
        tick();
        chk("rstmid_count_pre", int'(ifc.stall_count_o), 1);
        rst = 1'b1;
        tick();
        chk("rstmid_stall", int'(ifc.stall_o), 0);
        chk("rstmid_rs_sel", int'(ifc.rs_muxcontrol_o), 0);
        chk("rstmid_rt_sel", int'(ifc.rt_muxcontrol_o), 0);
        chk("rstmid_count", int'(ifc.stall_count_o), 0);
        rst = 1'b0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
